// File: rtl/prog_fetch.sv
// Instruction fetch unit: issues PC to program memory, checks the echoed tag,
// and hands decoded fields to execute over a valid/ready handshake.
module prog_fetch #(
    parameter int ADDR_W   = 4,
    parameter int INSTR_W  = 42,
    parameter int PROG_LEN = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [ADDR_W-1:0]         addr,
    input  logic [ADDR_W+INSTR_W-1:0] line,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [1:0]                out_mode,
    output logic [3:0]                out_op,
    output logic [11:0]               out_a,
    output logic [11:0]               out_b,
    output logic [11:0]               out_c,
    output logic                      fault,
    output logic                      halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALT,
        FAULT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    state_t state;

    logic [ADDR_W-1:0] tag;
    logic              slot_free;
    logic              consume;
    logic              bad_target;

    assign tag        = line[ADDR_W+INSTR_W-1:INSTR_W];
    assign slot_free  = !out_valid || out_ready;
    assign consume    = out_valid && out_ready;
    assign bad_target = redirect_addr > LAST;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_mode  <= '0;
            out_op    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            fault     <= 1'b0;
            halted    <= 1'b0;
        end else if (state != FAULT && redirect_valid) begin
            // Redirect flushes the held instruction and beats load/consume.
            out_valid <= 1'b0;
            halted    <= 1'b0;
            if (bad_target) begin
                state <= FAULT;
                fault <= 1'b1;
            end else begin
                state <= FETCH;
                addr  <= redirect_addr;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= FETCH;
                        addr  <= '0;
                    end
                end
                FETCH: begin
                    if (en && slot_free) begin
                        if (tag != addr) begin
                            state     <= FAULT;
                            fault     <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            out_pc    <= addr;
                            out_mode  <= line[41:40];
                            out_op    <= line[39:36];
                            out_a     <= line[35:24];
                            out_b     <= line[23:12];
                            out_c     <= line[11:0];
                            if (addr == LAST) begin
                                state <= DRAIN;
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end
                    end else if (consume) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (consume) begin
                        out_valid <= 1'b0;
                        state     <= HALT;
                        halted    <= 1'b1;
                    end
                end
                HALT: begin
                    out_valid <= 1'b0;
                    halted    <= 1'b1;
                end
                FAULT: begin
                    out_valid <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch.sv
// Directed bench for prog_fetch with a combinational program memory model.
module tb_prog_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  addr;
    logic [45:0] line;
    logic        redirect_valid;
    logic [3:0]  redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_pc;
    logic [1:0]  out_mode;
    logic [3:0]  out_op;
    logic [11:0] out_a;
    logic [11:0] out_b;
    logic [11:0] out_c;
    logic        fault;
    logic        halted;
    logic        corrupt;

    int n_cmp = 0;
    int n_err = 0;

    prog_fetch dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .addr(addr),
        .line(line),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_mode(out_mode),
        .out_op(out_op),
        .out_a(out_a),
        .out_b(out_b),
        .out_c(out_c),
        .fault(fault),
        .halted(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        line = {addr, 2'h0, 4'h5, {8'd0, addr} + 12'd1, 24'd0};
        if (corrupt && addr == 4'd3) line[45:42] = 4'hF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = 4'd0;
        corrupt = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({out_valid, fault, halted, addr} !== 7'd0) begin
            n_err++;
            $display("FAIL reset v/f/h/addr got %b want 0000000",
                     {out_valid, fault, halted, addr});
        end
        n_cmp++;
        if ({out_pc, out_op, out_a, out_b, out_c} !== 44'd0) begin
            n_err++;
            $display("FAIL reset_fields got %h want 0",
                     {out_pc, out_op, out_a, out_b, out_c});
        end
    endtask

    task automatic test_stream();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 4'(i) || out_op !== 4'h5
                || out_a !== 12'(i + 1) || out_mode !== 2'd0) begin
                n_err++;
                $display("FAIL stream%0d v=%b pc=%0d op=%h a=%0d want pc=%0d a=%0d",
                         i, out_valid, out_pc, out_op, out_a, i, i + 1);
            end
        end
        tick();
        n_cmp++;
        if (halted !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_halt h=%b v=%b want h=1 v=0", halted, out_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_a !== 12'd1 || addr !== 4'd1) begin
                n_err++;
                $display("FAIL stall%0d v=%b a=%0d addr=%0d want v=1 a=1 addr=1",
                         i, out_valid, out_a, addr);
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_a !== 12'd2 || out_pc !== 4'd1) begin
            n_err++;
            $display("FAIL stall_resume v=%b a=%0d pc=%0d want a=2 pc=1",
                     out_valid, out_a, out_pc);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== 4'd2) begin
            n_err++;
            $display("FAIL en_off v=%b addr=%0d want v=0 addr=2", out_valid, addr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 4'd4;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== 4'd4) begin
            n_err++;
            $display("FAIL redir_flush v=%b addr=%0d want v=0 addr=4", out_valid, addr);
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd4 || out_a !== 12'd5) begin
            n_err++;
            $display("FAIL redir_target v=%b pc=%0d a=%0d want pc=4 a=5",
                     out_valid, out_pc, out_a);
        end
    endtask

    task automatic test_tag_fault();
        do_reset();
        corrupt = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        tick();
        n_cmp++;
        if (fault !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL tag_fault f=%b v=%b want f=1 v=0", fault, out_valid);
        end
        redirect_valid = 1'b1;
        redirect_addr = 4'd0;
        tick();
        n_cmp++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || addr !== 4'd3) begin
            n_err++;
            $display("FAIL fault_sticky f=%b v=%b addr=%0d want f=1 v=0 addr=3",
                     fault, out_valid, addr);
        end
        do_reset();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_clear f=%b want 0", fault);
        end
    endtask

    task automatic test_bad_target();
        do_reset();
        en = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_addr = 4'd9;
        tick();
        n_cmp++;
        if (fault !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bad_target f=%b v=%b want f=1 v=0", fault, out_valid);
        end
    endtask

    task automatic test_halt_restart();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        repeat (9) tick();
        n_cmp++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_reach h=%b want 1", halted);
        end
        redirect_valid = 1'b1;
        redirect_addr = 4'd0;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if (halted !== 1'b0 || out_valid !== 1'b0 || addr !== 4'd0) begin
            n_err++;
            $display("FAIL halt_redir h=%b v=%b addr=%0d want h=0 v=0 addr=0",
                     halted, out_valid, addr);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd0 || out_a !== 12'd1) begin
            n_err++;
            $display("FAIL halt_restart v=%b pc=%0d a=%0d want pc=0 a=1",
                     out_valid, out_pc, out_a);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (out_pc !== 4'd3 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset pc=%0d v=%b want pc=3 v=1", out_pc, out_valid);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== 4'd0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset v=%b addr=%0d h=%b want 0/0/0",
                     out_valid, addr, halted);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== 4'd0) begin
            n_err++;
            $display("FAIL idle_step v=%b addr=%0d want v=0 addr=0", out_valid, addr);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
            n_err++;
            $display("FAIL idle_resume v=%b pc=%0d want v=1 pc=0", out_valid, out_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_tag_fault();
        test_bad_target();
        test_halt_restart();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
